// File: rtl/matvec_mac_engine.sv
// Matrix-vector multiply engine: y = A*x computed row by row on one MAC unit.
// Optional feature: define MATVEC_SAT_EN for a saturating accumulator (default wraps).
module matvec_mac_engine #(
   parameter int WORD_SIZE = 4,
   parameter int ROWS      = 2,
   parameter int COLS      = 2,
   parameter int ROW_BITS  = 1,
   parameter int COL_BITS  = 1,
   parameter int ACC_SIZE  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mat_wr_en,
   input  logic [WORD_SIZE-1:0] mat_wr_data,
   input  logic                 vec_wr_en,
   input  logic [WORD_SIZE-1:0] vec_wr_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 result_valid,
   output logic [ROW_BITS-1:0]  result_row,
   output logic [ACC_SIZE-1:0]  result_data,
   output logic                 done
);

   localparam int MAT_WORDS = ROWS * COLS;
   localparam int MAT_BITS  = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [WORD_SIZE-1:0]   mat_r [MAT_WORDS];
   logic [WORD_SIZE-1:0]   vec_r [COLS];
   logic [MAT_BITS-1:0]    mat_wr_ptr_r;
   logic [COL_BITS-1:0]    vec_wr_ptr_r;
   logic [ROW_BITS-1:0]    row_r;
   logic [COL_BITS-1:0]    col_r;
   logic [ACC_SIZE-1:0]    acc_r;
   logic [1:0]             state_r;
   logic [1:0]             state_nxt_s;
   logic                   busy_r;
   logic                   result_valid_r;
   logic [ROW_BITS-1:0]    result_row_r;
   logic [ACC_SIZE-1:0]    result_data_r;
   logic                   done_r;

   logic [MAT_BITS-1:0]    mac_idx_s;
   logic [2*WORD_SIZE-1:0] prod_full_s;
   logic [ACC_SIZE-1:0]    prod_acc_s;
   logic [ACC_SIZE-1:0]    acc_sum_s;
   logic                   last_col_s;
   logic                   last_row_s;
   logic                   mat_last_s;
   logic                   vec_last_s;
   logic                   idle_s;

   // Once saturated, adding a non-negative product keeps the accumulator pinned at all-ones.
   function automatic logic [ACC_SIZE-1:0] acc_add(input logic [ACC_SIZE-1:0] a,
                                                   input logic [ACC_SIZE-1:0] b);
`ifdef MATVEC_SAT_EN
      logic [ACC_SIZE:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[ACC_SIZE]) begin
         acc_add = {ACC_SIZE{1'b1}};
      end else begin
         acc_add = sum[ACC_SIZE-1:0];
      end
`else
      acc_add = a + b;
`endif
   endfunction

   assign idle_s      = (state_r == S_IDLE);
   assign last_col_s  = (col_r == COL_BITS'(COLS - 1));
   assign last_row_s  = (row_r == ROW_BITS'(ROWS - 1));
   assign mat_last_s  = (mat_wr_ptr_r == MAT_BITS'(MAT_WORDS - 1));
   assign vec_last_s  = (vec_wr_ptr_r == COL_BITS'(COLS - 1));
   assign mac_idx_s   = MAT_BITS'(32'(row_r) * COLS + 32'(col_r));
   assign prod_full_s = {{WORD_SIZE{1'b0}}, mat_r[mac_idx_s]} * {{WORD_SIZE{1'b0}}, vec_r[col_r]};
   assign prod_acc_s  = ACC_SIZE'(prod_full_s);
   assign acc_sum_s   = acc_add(acc_r, prod_acc_s);

   // Next-state decode for the IDLE/MAC/OUT/DONE sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_MAC;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_MAC: begin
            if (last_col_s) begin
               state_nxt_s = S_OUT;
            end else begin
               state_nxt_s = S_MAC;
            end
         end
         S_OUT: begin
            if (last_row_s) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_MAC;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Matrix/vector storage and their auto-incrementing write pointers (IDLE only).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAT_WORDS; i++) begin
            mat_r[i] <= {WORD_SIZE{1'b0}};
         end
         for (int j = 0; j < COLS; j++) begin
            vec_r[j] <= {WORD_SIZE{1'b0}};
         end
         mat_wr_ptr_r <= {MAT_BITS{1'b0}};
         vec_wr_ptr_r <= {COL_BITS{1'b0}};
      end else begin
         if (idle_s && mat_wr_en) begin
            mat_r[mat_wr_ptr_r] <= mat_wr_data;
            mat_wr_ptr_r        <= mat_last_s ? {MAT_BITS{1'b0}} : mat_wr_ptr_r + MAT_BITS'(1);
         end
         if (idle_s && vec_wr_en) begin
            vec_r[vec_wr_ptr_r] <= vec_wr_data;
            vec_wr_ptr_r        <= vec_last_s ? {COL_BITS{1'b0}} : vec_wr_ptr_r + COL_BITS'(1);
         end
      end
   end

   // Sequencer, MAC datapath and registered outputs; strobes are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         row_r          <= {ROW_BITS{1'b0}};
         col_r          <= {COL_BITS{1'b0}};
         acc_r          <= {ACC_SIZE{1'b0}};
         busy_r         <= 1'b0;
         result_valid_r <= 1'b0;
         result_row_r   <= {ROW_BITS{1'b0}};
         result_data_r  <= {ACC_SIZE{1'b0}};
         done_r         <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         busy_r         <= (state_nxt_s != S_IDLE);
         result_valid_r <= (state_nxt_s == S_OUT);
         done_r         <= (state_nxt_s == S_DONE);
         if (state_nxt_s == S_OUT) begin
            result_row_r  <= row_r;
            result_data_r <= acc_sum_s;
         end
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  row_r <= {ROW_BITS{1'b0}};
                  col_r <= {COL_BITS{1'b0}};
                  acc_r <= {ACC_SIZE{1'b0}};
               end
            end
            S_MAC: begin
               acc_r <= acc_sum_s;
               col_r <= last_col_s ? {COL_BITS{1'b0}} : col_r + COL_BITS'(1);
            end
            S_OUT: begin
               if (!last_row_s) begin
                  row_r <= row_r + ROW_BITS'(1);
                  col_r <= {COL_BITS{1'b0}};
                  acc_r <= {ACC_SIZE{1'b0}};
               end
            end
            S_DONE: begin
               col_r <= {COL_BITS{1'b0}};
            end
            default: begin
               col_r <= {COL_BITS{1'b0}};
            end
         endcase
      end
   end

   assign busy         = busy_r;
   assign result_valid = result_valid_r;
   assign result_row   = result_row_r;
   assign result_data  = result_data_r;
   assign done         = done_r;

endmodule

// File: tb/tb_matvec_mac_engine.sv
// Directed self-checking bench for matvec_mac_engine (default 2x2, 4-bit elements, 8-bit results).
module tb_matvec_mac_engine;

   logic       clk;
   logic       rst;
   logic       mat_wr_en;
   logic [3:0] mat_wr_data;
   logic       vec_wr_en;
   logic [3:0] vec_wr_data;
   logic       start;
   logic       busy;
   logic       result_valid;
   logic [0:0] result_row;
   logic [7:0] result_data;
   logic       done;

   int checks = 0;
   int errors = 0;

   matvec_mac_engine dut (
      .clk          (clk),
      .rst          (rst),
      .mat_wr_en    (mat_wr_en),
      .mat_wr_data  (mat_wr_data),
      .vec_wr_en    (vec_wr_en),
      .vec_wr_data  (vec_wr_data),
      .start        (start),
      .busy         (busy),
      .result_valid (result_valid),
      .result_row   (result_row),
      .result_data  (result_data),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         mat_wr_en   = 1'($urandom);
         mat_wr_data = 4'($urandom);
         vec_wr_en   = 1'($urandom);
         vec_wr_data = 4'($urandom);
         start       = 1'($urandom);
         tick();
      end
      rst = 1'b0;
      mat_wr_en = 1'b0; mat_wr_data = 4'd0;
      vec_wr_en = 1'b0; vec_wr_data = 4'd0;
      start = 1'b0;
   endtask

   task automatic wr_mat(input logic [3:0] d);
      mat_wr_en = 1'b1; mat_wr_data = d;
      tick();
      mat_wr_en = 1'b0;
   endtask

   task automatic wr_vec(input logic [3:0] d);
      vec_wr_en = 1'b1; vec_wr_data = d;
      tick();
      vec_wr_en = 1'b0;
   endtask

   // Start at edge 0, then check every cycle 1..8 against the fixed 2x2 schedule.
   task automatic run_mat(input string tag, input logic [7:0] e0, input logic [7:0] e1, input bit junk);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (junk && cyc <= 6) begin
            mat_wr_en = 1'b1; mat_wr_data = 4'd15;
            vec_wr_en = 1'b1; vec_wr_data = 4'd15;
         end else begin
            mat_wr_en = 1'b0; vec_wr_en = 1'b0;
         end
         chk({tag, " busy"},  busy,         32'(cyc <= 7));
         chk({tag, " valid"}, result_valid, 32'(cyc == 3 || cyc == 6));
         chk({tag, " done"},  done,         32'(cyc == 7));
         if (cyc == 3) begin
            chk({tag, " row0 idx"},  result_row,  32'd0);
            chk({tag, " row0 data"}, result_data, 32'(e0));
         end
         if (cyc == 6 || cyc == 8) begin
            chk({tag, " row1 idx"},  result_row,  32'd1);
            chk({tag, " row1 data"}, result_data, 32'(e1));
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      mat_wr_en = 1'b0; mat_wr_data = 4'd0;
      vec_wr_en = 1'b0; vec_wr_data = 4'd0;
      start = 1'b0;
      #2;

      do_reset();
      chk("reset busy",  busy,         32'd0);
      chk("reset valid", result_valid, 32'd0);
      chk("reset done",  done,         32'd0);
      chk("reset data",  result_data,  32'd0);
      chk("reset row",   result_row,   32'd0);
      run_mat("post-reset", 8'd0, 8'd0, 1'b0);

      // A=[1 2;3 4], x=[5 6] -> y=[17 39]
      wr_mat(4'd1); wr_mat(4'd2); wr_mat(4'd3); wr_mat(4'd4);
      wr_vec(4'd5); wr_vec(4'd6);
      run_mat("basic", 8'd17, 8'd39, 1'b0);

      run_mat("busy-writes", 8'd17, 8'd39, 1'b1);
      wr_mat(4'd9);
      run_mat("a00=9", 8'd57, 8'd39, 1'b0);

      // Fifth write wraps onto A[0][0]: A=[7 2;3 4], x=[1 1]
      do_reset();
      wr_mat(4'd1); wr_mat(4'd2); wr_mat(4'd3); wr_mat(4'd4); wr_mat(4'd7);
      wr_vec(4'd1); wr_vec(4'd1);
      run_mat("wrap", 8'd9, 8'd7, 1'b0);

      do_reset();
      repeat (4) wr_mat(4'd15);
      wr_vec(4'd15); wr_vec(4'd15);
`ifdef MATVEC_SAT_EN
      run_mat("overflow", 8'd255, 8'd255, 1'b0);
`else
      run_mat("overflow", 8'd194, 8'd194, 1'b0);
`endif

      // Reset during cycle 2 of a computation aborts it.
      do_reset();
      wr_mat(4'd1); wr_mat(4'd2); wr_mat(4'd3); wr_mat(4'd4);
      wr_vec(4'd5); wr_vec(4'd6);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("midrst c1 busy", busy, 32'd1);
      tick();
      chk("midrst c2 busy", busy, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst c3 busy",  busy,         32'd0);
      chk("midrst c3 valid", result_valid, 32'd0);
      chk("midrst c3 data",  result_data,  32'd0);
      for (int k = 4; k <= 9; k++) begin
         chk("midrst valid", result_valid, 32'd0);
         chk("midrst done",  done,         32'd0);
         tick();
      end
      run_mat("after-midrst", 8'd0, 8'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
